// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default parameters and the baud divisor
// helper for the UART transmit channel.
package uart_pkg;

    localparam int DEF_BYTESIZES   = 8;
    localparam int DEF_BAUDRATE    = 115200;
    localparam int DEF_CLOCK_INPUT = 50_000_000;
    localparam int STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        T_DATA  = 3'd2,
        PARITY  = 3'd3,
        STOPBIT = 3'd4
    } uart_tx_state_t;

    // Clocks per serial bit; integer division, remainder dropped.
    function automatic int calc_divisor(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider. Counts 0..DIVISOR-1 while run is high
// and flags the last count of each bit; held at zero whenever run is low.
module uart_baud_tick #(
    parameter int DIVISOR = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear when stopped, wrap after the last count of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with asynchronous clear.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmit channel. Accepts a word over valid/ready and sends
// start bit, data LSB first, optional even parity, and one stop bit.
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BYTESIZES   = DEF_BYTESIZES,
    parameter int BAUDRATE    = DEF_BAUDRATE,
    parameter int CLOCK_INPUT = DEF_CLOCK_INPUT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_tx_in,
    input  logic [BYTESIZES-1:0] data_tx_in,
    output logic                 ready_tx_out,
    output logic                 sdata_tx_out,
    output logic                 done_tx_out
);

    localparam int            DIVISOR  = calc_divisor(CLOCK_INPUT, BAUDRATE);
    localparam int            IW       = $clog2(BYTESIZES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTESIZES - 1);

    if (DIVISOR < 2) begin : g_divisor_check
        $error("uart_tx: CLOCK_INPUT / BAUDRATE must be at least 2");
    end

    uart_tx_state_t       state_q, state_d;
    logic [BYTESIZES-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic                 sdata_q, sdata_d;
    logic                 ready_q, ready_d;
    logic                 done_q,  done_d;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q,   par_d;
`endif

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clock (clock),
        .reset (reset),
        .run   (state_q != IDLE),
        .tick  (tick)
    );

    // Frame sequencing; the line value for the next bit is computed here so
    // sdata_tx_out comes straight from a flop.
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        sdata_d = sdata_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_tx_in && ready_q) begin
                    state_d = START;
                    shift_d = data_tx_in;
                    idx_d   = '0;
                    sdata_d = 1'b0;
                    ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^data_tx_in;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = T_DATA;
                    idx_d   = '0;
                    sdata_d = shift_q[0];
                end
            end
            T_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        sdata_d = par_q;
`else
                        state_d = STOPBIT;
                        sdata_d = 1'b1;
`endif
                    end else begin
                        sdata_d = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOPBIT;
                    sdata_d = 1'b1;
                end
            end
`endif
            STOPBIT: begin
                if (tick) begin
                    state_d = IDLE;
                    sdata_d = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sdata_d = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            sdata_q <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            sdata_q <= sdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign sdata_tx_out = sdata_q;
    assign ready_tx_out = ready_q;
    assign done_tx_out  = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit channel of the UART block. It is the counterpart to the receive channel and uses the same frame format: one start bit (low), BYTESIZES data bits LSB first, an optional even-parity bit, and one stop bit (high). It accepts a parallel word through a valid/ready handshake and shifts it out on `sdata_tx_out` at the configured baud rate. An internal divider generates the bit timing, so the block needs no external enable.

## Interface
- BYTESIZES, 8, data bits per frame; 1 to 16.
- BAUDRATE, 115200, line bit rate in bit/s.
- CLOCK_INPUT, 50_000_000, frequency of `clock` in Hz.
- `clock`  input  1  system clock; all logic on posedge.
- `reset`  input  1  asynchronous, active-high reset.
- `valid_tx_in`  input  1  `data_tx_in` holds a word to send.
- `data_tx_in`  input  BYTESIZES  word to transmit; sampled only at acceptance.
- `ready_tx_out`  output  1  block is idle and can accept a word.
- `sdata_tx_out`  output  1  serial line; idles high.
- `done_tx_out`  output  1  one-cycle pulse when a stop bit completes.

## Operation
- DIVISOR = CLOCK_INPUT / BAUDRATE (integer division).
  - DIVISOR < 2 is an elaboration error.
  - Divider counter width is $clog2(DIVISOR).
  - Bit index width is $clog2(BYTESIZES+1).
- Acceptance happens at a posedge where `valid_tx_in` and `ready_tx_out` are both 1.
  - At that edge, `data_tx_in` is captured into the shift register.
  - The divider counter clears to 0.
- `valid_tx_in` while not ready is ignored; no queuing.
- Changes on `data_tx_in` after acceptance have no effect on the frame in progress.
- FSM states, with exactly DIVISOR clocks per bit:
  - IDLE: line 1, ready 1. Goes to START on acceptance.
  - START: line 0 for DIVISOR clocks, then T_DATA with index 0.
  - T_DATA: line = shift[0]. Each bit-end tick shifts right and increments the index. After bit BYTESIZES-1 it goes to PARITY if UART_TX_PARITY_EN is defined, otherwise to STOPBIT.
  - PARITY: line = XOR of the captured word (even parity) for DIVISOR clocks, then STOPBIT.
  - STOPBIT: line 1 for DIVISOR clocks. At the final tick: go to IDLE and pulse `done_tx_out`.
- The bit-end tick fires when the divider counter reaches DIVISOR-1; the counter then wraps to 0.
  - The counter runs only outside IDLE.
- `sdata_tx_out`, `ready_tx_out` and `done_tx_out` are registered outputs with no combinational paths from inputs.
- Reset values, applied immediately on `reset`:
  - state IDLE, `sdata_tx_out` 1, `ready_tx_out` 1, `done_tx_out` 0.
  - Shift register, bit index and divider counter all 0.
- Reset mid-frame aborts the frame. The line goes high asynchronously; no partial stop bit and no `done_tx_out`.

## Timing
- Acceptance at edge k:
  - `ready_tx_out` is 0 and `sdata_tx_out` is 0 from edge k onward.
  - Start bit spans edges k to k+DIVISOR.
- Frame length F = (BYTESIZES+2)*DIVISOR clocks, plus DIVISOR when parity is enabled.
- At edge k+F:
  - `sdata_tx_out` is 1 (stop bit end; the line stays idle).
  - `done_tx_out` is 1 for exactly one cycle.
  - `ready_tx_out` returns to 1.
- Earliest next acceptance is edge k+F+1.
  - Back-to-back frame period is F+1 clocks, i.e. at least one idle clock between frames.
  - `valid_tx_in` held high continuously produces frames every F+1 clocks.
- When `done_tx_out` and acceptance would coincide: not possible, because ready is 0 until the edge after done.

## Configuration
- UART_TX_PARITY_EN
  - Defined: a PARITY state inserts one even-parity bit between the last data bit and the stop bit. F grows by DIVISOR.
  - Undefined: the PARITY state and the XOR logic are not compiled. The frame is 8N1-style (BYTESIZES data bits, no parity, one stop bit).

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` {IDLE, START, T_DATA, PARITY, STOPBIT}, encoded in 3 bits;
  - a function computing DIVISOR from CLOCK_INPUT and BAUDRATE;
  - the width constants.
- Sub-module `uart_baud_tick` holds the divider counter.
  - Inputs: `clock`, `reset`, `run`.
  - Output: `tick`, asserted at count DIVISOR-1.
  - Counter clears whenever `run` is 0.
- FSM and shift register stay in `uart_tx`.

## Test plan
Bench uses CLOCK_INPUT=8, BAUDRATE=1, so DIVISOR=8.
- Reset asserted mid-idle -> `sdata_tx_out`=1, `ready_tx_out`=1, `done_tx_out`=0 immediately.
- Send 0xA5, no parity -> line 0, 1,0,1,0,0,1,0,1, then 1, each bit 8 clocks. `done_tx_out` pulses 80 clocks after acceptance. Ready is low for those 80 clocks.
- With UART_TX_PARITY_EN, send 0xA5 then 0x07:
  - 0xA5 frame has a parity bit of 0 and F=88.
  - 0x07 frame has a parity bit of 1.
- `valid_tx_in` held high with 0x00 then 0xFF -> frames start exactly 81 clocks apart. Each word is sent intact, with no dropped or duplicated frame.
- `data_tx_in` changed and `valid_tx_in` pulsed during a frame -> the frame in progress is unaltered and no extra frame is sent.
- Reset asserted during data bit 3 -> line goes high immediately, no `done_tx_out` pulse. A new word is accepted on the first edge after reset deasserts.
